// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: FSM state encodings and default timing constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_pkg;

  // Default debounce and long-press hold counts for a 50 MHz sys_clk.
  localparam int CNT_MAX_DFLT     = 999_999;     // 20 ms
  localparam int LONG_MAX_DFLT    = 49_999_999;  // 1 s
  localparam int SYNC_STAGES_DFLT = 2;

  // One-hot debounce FSM encoding.
  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    PRESS_FLT = 4'b0010,
    DOWN      = 4'b0100,
    REL_FLT   = 4'b1000
  } key_fsm_e;

endpackage

// File: rtl/key_filter_if.sv
// Key conditioner bundle: raw key and busy in, debounced level and press pulses out.
// Latency: n/a (wiring only).
// Backpressure: busy from the downstream controller defers key_flag.
// Ports (master = key_filter side): key_in, busy -> filter; key_flag, key_state -> downstream.
// key_long is present only when KEY_LONG_EN is defined.
interface key_filter_if;
  logic key_in;     // raw button, active-low, asynchronous
  logic busy;       // downstream controller cannot accept key_flag
  logic key_flag;   // one-cycle confirmed-press pulse
  logic key_state;  // debounced level, 1 = released
`ifdef KEY_LONG_EN
  logic key_long;   // one-cycle long-press pulse

  modport master (input key_in, busy, output key_flag, key_state, key_long);
  modport slave  (output key_in, busy, input key_flag, key_state, key_long);
`else
  modport master (input key_in, busy, output key_flag, key_state);
  modport slave  (output key_in, busy, input key_flag, key_state);
`endif
endinterface

// File: rtl/key_sync.sv
// Multi-flop synchroniser for the raw asynchronous key input; resets to 1 (released).
// Latency: STAGES cycles from i_d to o_q.
// Backpressure: none.
// Ports: i_clk, i_rst_n (async active-low), i_d (async in), o_q (synchronised out).
module key_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/key_filter.sv
// Push-button conditioner: synchronise, debounce press/release, one key_flag per confirmed press.
// Latency: key_state falls SYNC_STAGES+CNT_MAX+1 cycles after key_in settles low; key_flag one cycle later.
// Backpressure: busy holds a single pending press; extra presses while pending are dropped.
// Ports: sys_clk, sys_rst_n (async active-low), kif (key_filter_if.master: key_in, busy,
// key_flag, key_state, and key_long when KEY_LONG_EN is defined).
module key_filter
  import key_pkg::*;
#(
  parameter int CNT_MAX     = CNT_MAX_DFLT,
  parameter int SYNC_STAGES = SYNC_STAGES_DFLT
`ifdef KEY_LONG_EN
  ,
  parameter int LONG_MAX    = LONG_MAX_DFLT
`endif
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  key_filter_if.master        kif
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

  logic          w_key_s;
  logic [CW-1:0] w_cnt_inc;
  logic          w_issue;

  key_fsm_e      r_state;
  logic [CW-1:0] r_cnt;
  logic          r_key_state;
  logic          r_pending;
  logic          r_key_flag;

  key_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (kif.key_in),
    .o_q     (w_key_s)
  );

  assign w_cnt_inc = r_cnt + CW'(1);
  // ~r_key_flag makes a back-to-back pulse impossible even if a new confirm lands on the issue edge.
  assign w_issue   = r_pending & ~kif.busy & ~r_key_flag;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_key_state <= 1'b1;
      r_pending   <= 1'b0;
      r_key_flag  <= 1'b0;
    end else begin
      r_key_flag <= w_issue;
      if (w_issue) r_pending <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_key_s) r_state <= PRESS_FLT;
        end
        PRESS_FLT: begin
          if (w_key_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_cnt_inc == CNT_LAST) begin
            // Confirm on the edge the count reaches CNT_MAX. Setting pending here
            // overrides the clear above, so a confirm on an issue edge is kept.
            r_state     <= DOWN;
            r_cnt       <= '0;
            r_key_state <= 1'b0;
            r_pending   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DOWN: begin
          r_cnt <= '0;
          if (w_key_s) r_state <= REL_FLT;
        end
        REL_FLT: begin
          if (!w_key_s) begin
            r_state <= DOWN;
            r_cnt   <= '0;
          end else if (w_cnt_inc == CNT_LAST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_key_state <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign kif.key_flag  = r_key_flag;
  assign kif.key_state = r_key_state;

`ifdef KEY_LONG_EN
  localparam int LW = $clog2(LONG_MAX + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX);

  logic [LW-1:0] r_lcnt;
  logic          r_long_done;
  logic          r_key_long;

  // Counts only while DOWN (paused across release bounces) and re-arms in IDLE,
  // so key_long fires at most once per press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_lcnt      <= '0;
      r_long_done <= 1'b0;
      r_key_long  <= 1'b0;
    end else begin
      r_key_long <= 1'b0;
      if (r_state == IDLE) begin
        r_lcnt      <= '0;
        r_long_done <= 1'b0;
      end else if (r_state == DOWN) begin
        if (r_lcnt != LONG_LAST) begin
          r_lcnt <= r_lcnt + LW'(1);
        end else if (!r_long_done) begin
          r_key_long  <= 1'b1;
          r_long_done <= 1'b1;
        end
      end
    end
  end

  assign kif.key_long = r_key_long;
`endif

endmodule
